// File: rtl/load_module.sv
// Load-side DECTED checker/corrector: searches weight-0/1/2 data masks against the
// stored 16-bit check field. Optional scrub write-back outputs under DECTED_SCRUB_EN.

// Check bits [6:0]: index XOR of set data bits, its parity, and data parity.
module Parity_Encoder_A (
  input  logic [31:0] i_data,
  output logic [6:0]  o_parity
);
  logic [4:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < 32; k++) begin
      if (i_data[k]) w_acc = w_acc ^ 5'(k);
    end
    o_parity = {^i_data, ^w_acc, w_acc};
  end
endmodule

// Check bits [14:7]: XOR of GF(32) cubes of set-bit indices, plus data parity x3.
module Parity_Encoder_B (
  input  logic [31:0] i_data,
  output logic [7:0]  o_parity
);
  logic [4:0] w_acc;

  // GF(32) multiply, reduction polynomial x^5 + x^2 + 1
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] r;
    r = '0;
    for (int i = 4; i >= 0; i--) begin
      r = {r[3:0], 1'b0} ^ (r[4] ? 5'b00101 : 5'b00000);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < 32; k++) begin
      if (i_data[k]) w_acc = w_acc ^ gf_mul(5'(k), gf_mul(5'(k), 5'(k)));
    end
    o_parity = {{3{^i_data}}, w_acc};
  end
endmodule

module load_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] data_Cache,
  input  logic [15:0] parity_Cache,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_PC,
  output logic        err_corrected,
  output logic        err_uncorrectable,
  output logic [1:0]  err_nbits,
  output logic [4:0]  err_pos0,
  output logic [4:0]  err_pos1,
  output logic [15:0] corr_count,
  output logic [15:0] uncorr_count
`ifdef DECTED_SCRUB_EN
  ,
  output logic        scrub_req,
  output logic [31:0] scrub_data,
  output logic [15:0] scrub_parity
`endif
);
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SEARCH1, S_SEARCH2, S_NOFIT, S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_d;
  logic [15:0] r_p;
  logic [4:0]  r_i, r_j;
  logic        r_load_ready, r_out_valid, r_err_corrected, r_err_uncorrectable;
  logic [31:0] r_data_pc;
  logic [1:0]  r_err_nbits;
  logic [4:0]  r_err_pos0, r_err_pos1;
  logic [15:0] r_corr_count, r_uncorr_count;
  logic        r_scrub_req;
  logic [31:0] r_scrub_data;
  logic [15:0] r_scrub_parity;

  logic [31:0] w_mask, w_cand;
  logic [1:0]  w_w;
  logic [6:0]  w_enc_a;
  logic [7:0]  w_enc_b;
  logic [15:0] w_enc, w_diff;
  logic [4:0]  w_dist;
  logic [5:0]  w_score;
  logic        w_searching, w_fit;

  // Candidate mask for the current search step
  always_comb begin
    w_mask = '0;
    w_w    = 2'd0;
    case (r_state)
      S_SEARCH1: begin
        w_mask[r_i] = 1'b1;
        w_w         = 2'd1;
      end
      S_SEARCH2: begin
        w_mask[r_i] = 1'b1;
        w_mask[r_j] = 1'b1;
        w_w         = 2'd2;
      end
      default: ;
    endcase
  end

  assign w_cand = r_d ^ w_mask;

  Parity_Encoder_A u_enc_a (.i_data(w_cand), .o_parity(w_enc_a));
  Parity_Encoder_B u_enc_b (.i_data(w_cand), .o_parity(w_enc_b));

  assign w_enc  = {^w_enc_b, w_enc_b, w_enc_a};
  assign w_diff = w_enc ^ r_p;

  always_comb begin
    w_dist = '0;
    for (int b = 0; b < 16; b++) w_dist = w_dist + 5'(w_diff[b]);
  end

  assign w_score     = 6'(w_dist) + 6'(w_w);
  assign w_fit       = (w_score <= 6'd2);
  assign w_searching = (r_state == S_CHECK) || (r_state == S_SEARCH1) || (r_state == S_SEARCH2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state             <= S_IDLE;
      r_d                 <= '0;
      r_p                 <= '0;
      r_i                 <= '0;
      r_j                 <= '0;
      r_load_ready        <= 1'b1;
      r_out_valid         <= 1'b0;
      r_data_pc           <= '0;
      r_err_corrected     <= 1'b0;
      r_err_uncorrectable <= 1'b0;
      r_err_nbits         <= '0;
      r_err_pos0          <= '0;
      r_err_pos1          <= '0;
      r_corr_count        <= '0;
      r_uncorr_count      <= '0;
      r_scrub_req         <= 1'b0;
      r_scrub_data        <= '0;
      r_scrub_parity      <= '0;
    end else begin
      r_scrub_req <= 1'b0;
      if (w_searching && w_fit) begin
        r_state             <= S_DONE;
        r_out_valid         <= 1'b1;
        r_data_pc           <= w_cand;
        r_err_corrected     <= (w_score != 6'd0);
        r_err_uncorrectable <= 1'b0;
        r_err_nbits         <= w_w;
        r_err_pos0          <= (w_w != 2'd0) ? r_i : 5'd0;
        r_err_pos1          <= (w_w == 2'd2) ? r_j : 5'd0;
        r_scrub_req         <= (w_score != 6'd0);
        r_scrub_data        <= w_cand;
        r_scrub_parity      <= w_enc;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (load_valid) begin
              r_d          <= data_Cache;
              r_p          <= parity_Cache;
              r_load_ready <= 1'b0;
              r_state      <= S_CHECK;
            end
          end
          S_CHECK: begin
            r_i     <= 5'd0;
            r_state <= S_SEARCH1;
          end
          S_SEARCH1: begin
            if (r_i == 5'd31) begin
              r_i     <= 5'd0;
              r_j     <= 5'd1;
              r_state <= S_SEARCH2;
            end else begin
              r_i <= r_i + 5'd1;
            end
          end
          S_SEARCH2: begin
            // Pairs walk (i,j) lexicographically with i<j
            if (r_i == 5'd30 && r_j == 5'd31) begin
              r_state <= S_NOFIT;
            end else if (r_j == 5'd31) begin
              r_i <= r_i + 5'd1;
              r_j <= r_i + 5'd2;
            end else begin
              r_j <= r_j + 5'd1;
            end
          end
          S_NOFIT: begin
            r_state             <= S_DONE;
            r_out_valid         <= 1'b1;
            r_data_pc           <= r_d;
            r_err_corrected     <= 1'b0;
            r_err_uncorrectable <= 1'b1;
            r_err_nbits         <= 2'd0;
            r_err_pos0          <= 5'd0;
            r_err_pos1          <= 5'd0;
          end
          S_DONE: begin
            if (out_ready) begin
              r_out_valid  <= 1'b0;
              r_load_ready <= 1'b1;
              r_state      <= S_IDLE;
              if (r_err_corrected && r_corr_count != 16'hFFFF)
                r_corr_count <= r_corr_count + 16'd1;
              if (r_err_uncorrectable && r_uncorr_count != 16'hFFFF)
                r_uncorr_count <= r_uncorr_count + 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign load_ready        = r_load_ready;
  assign out_valid         = r_out_valid;
  assign data_PC           = r_data_pc;
  assign err_corrected     = r_err_corrected;
  assign err_uncorrectable = r_err_uncorrectable;
  assign err_nbits         = r_err_nbits;
  assign err_pos0          = r_err_pos0;
  assign err_pos1          = r_err_pos1;
  assign corr_count        = r_corr_count;
  assign uncorr_count      = r_uncorr_count;

`ifdef DECTED_SCRUB_EN
  assign scrub_req    = r_scrub_req;
  assign scrub_data   = r_scrub_data;
  assign scrub_parity = r_scrub_parity;
`else
  logic w_unused_scrub;
  assign w_unused_scrub = ^{r_scrub_req, r_scrub_data, r_scrub_parity};
`endif
endmodule

// File: tb/tb_load_module.sv
// Directed self-checking bench for load_module (DECTED search corrector).
module tb_load_module;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] data_Cache = '0;
  logic [15:0] parity_Cache = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] data_PC;
  logic        err_corrected, err_uncorrectable;
  logic [1:0]  err_nbits;
  logic [4:0]  err_pos0, err_pos1;
  logic [15:0] corr_count, uncorr_count;
`ifdef DECTED_SCRUB_EN
  logic        scrub_req;
  logic [31:0] scrub_data;
  logic [15:0] scrub_parity;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_corr = 0;
  int exp_unc  = 0;

  always #5 clk = ~clk;

  load_module dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .data_Cache(data_Cache), .parity_Cache(parity_Cache),
    .out_valid(out_valid), .out_ready(out_ready), .data_PC(data_PC),
    .err_corrected(err_corrected), .err_uncorrectable(err_uncorrectable),
    .err_nbits(err_nbits), .err_pos0(err_pos0), .err_pos1(err_pos1),
    .corr_count(corr_count), .uncorr_count(uncorr_count)
`ifdef DECTED_SCRUB_EN
    , .scrub_req(scrub_req), .scrub_data(scrub_data), .scrub_parity(scrub_parity)
`endif
  );

  // Carry-less product then polynomial reduction by x^5+x^2+1 (0x25)
  function automatic int gf_mul_ref(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 5; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int bit_i = 8; bit_i >= 5; bit_i--)
      if (((p >> bit_i) & 1) != 0) p = p ^ (37 << (bit_i - 5));
    return p;
  endfunction

  function automatic logic [15:0] ref_check(input logic [31:0] d);
    int   xa, xb;
    logic dp;
    logic [6:0] a;
    logic [7:0] b;
    xa = 0;
    xb = 0;
    dp = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (d[k]) begin
        xa = xa ^ k;
        xb = xb ^ gf_mul_ref(gf_mul_ref(k, k), k);
        dp = ~dp;
      end
    end
    a = {dp, ^(5'(xa)), 5'(xa)};
    b = {dp, dp, dp, 5'(xb)};
    return {^b, b, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word, time out_valid from the accept edge, check result and handshake
  task automatic run_case(input string tag, input logic [31:0] d, input logic [15:0] p,
                          input int exp_edge, input logic [31:0] exp_data,
                          input logic exp_c, input logic exp_u, input logic [1:0] nb,
                          input logic [4:0] p0, input logic [4:0] p1, input int hold);
    int cnt;
    @(negedge clk);
    out_ready    = (hold == 0);
    load_valid   = 1'b1;
    data_Cache   = d;
    parity_Cache = p;
    chk({tag, "/ready_in"}, 32'(load_ready), 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 600) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, "/edge"}, 32'(cnt), 32'(exp_edge));
    chk({tag, "/data"}, data_PC, exp_data);
    chk({tag, "/corr"}, 32'(err_corrected), 32'(exp_c));
    chk({tag, "/uncorr"}, 32'(err_uncorrectable), 32'(exp_u));
    chk({tag, "/nbits"}, 32'(err_nbits), 32'(nb));
    chk({tag, "/pos0"}, 32'(err_pos0), 32'(p0));
    chk({tag, "/pos1"}, 32'(err_pos1), 32'(p1));
    chk({tag, "/ready_busy"}, 32'(load_ready), 32'd0);
`ifdef DECTED_SCRUB_EN
    chk({tag, "/scrub_req"}, 32'(scrub_req), 32'(exp_c));
    if (exp_c) begin
      chk({tag, "/scrub_data"}, scrub_data, exp_data);
      chk({tag, "/scrub_par"}, 32'(scrub_parity), 32'(ref_check(exp_data)));
    end
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "/hold_data"}, data_PC, exp_data);
      chk({tag, "/hold_nbits"}, 32'(err_nbits), 32'(nb));
      chk({tag, "/hold_ready"}, 32'(load_ready), 32'd0);
    end
    if (hold != 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    if (exp_c) exp_corr++;
    if (exp_u) exp_unc++;
    chk({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "/ready_back"}, 32'(load_ready), 32'd1);
    chk({tag, "/corr_cnt"}, 32'(corr_count), 32'(exp_corr));
    chk({tag, "/uncorr_cnt"}, 32'(uncorr_count), 32'(exp_unc));
`ifdef DECTED_SCRUB_EN
    chk({tag, "/scrub_pulse"}, 32'(scrub_req), 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] p_beef, p_zero, p_ones, p_1234;
    p_beef = ref_check(32'hDEADBEEF);
    p_zero = ref_check(32'h00000000);
    p_ones = ref_check(32'hFFFFFFFF);
    p_1234 = ref_check(32'h12345678);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst/ready", 32'(load_ready), 32'd1);
    chk("rst/valid", 32'(out_valid), 32'd0);
    chk("rst/data", data_PC, 32'd0);
    chk("rst/counts", {corr_count, uncorr_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case("clean", 32'hDEADBEEF, p_beef, 1, 32'hDEADBEEF, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 0);
    run_case("single7", 32'hDEADBE6F, p_beef, 9, 32'hDEADBEEF, 1'b1, 1'b0, 2'd1, 5'd7, 5'd0, 0);
    run_case("double3_30", 32'h9EADBEE7, p_beef, 150, 32'hDEADBEEF, 1'b1, 1'b0, 2'd2, 5'd3, 5'd30, 0);
    run_case("mixed_d0_c15", 32'hDEADBEEE, p_beef ^ 16'h8000, 2, 32'hDEADBEEF, 1'b1, 1'b0, 2'd1, 5'd0, 5'd0, 0);
    run_case("check2_9", 32'hDEADBEEF, p_beef ^ 16'h0204, 1, 32'hDEADBEEF, 1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 0);
    run_case("triple", 32'hDEADBEE1, p_beef, 530, 32'hDEADBEE1, 1'b0, 1'b1, 2'd0, 5'd0, 5'd0, 0);
    run_case("single31", 32'h80000000, p_zero, 33, 32'h00000000, 1'b1, 1'b0, 2'd1, 5'd31, 5'd0, 0);
    run_case("double30_31", 32'h3FFFFFFF, p_ones, 529, 32'hFFFFFFFF, 1'b1, 1'b0, 2'd2, 5'd30, 5'd31, 0);
    run_case("bp_double0_1", 32'h1234567B, p_1234, 34, 32'h12345678, 1'b1, 1'b0, 2'd2, 5'd0, 5'd1, 10);

    // Reset while the search is in its pair phase
    @(negedge clk);
    load_valid   = 1'b1;
    data_Cache   = 32'hDEADBEE1;
    parity_Cache = p_beef;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("midrst/busy_valid", 32'(out_valid), 32'd0);
    chk("midrst/busy_ready", 32'(load_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_corr = 0;
    exp_unc  = 0;
    chk("midrst/ready", 32'(load_ready), 32'd1);
    chk("midrst/valid", 32'(out_valid), 32'd0);
    chk("midrst/counts", {corr_count, uncorr_count}, 32'd0);
    chk("midrst/flags", {29'd0, err_corrected, err_uncorrectable, 1'b0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case("post_rst_clean", 32'h12345678, p_1234, 1, 32'h12345678, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
